dbg_store_sniffer: RTL and testbench

- Memory-mapped store responder on the CPU data-memory interface: watches `memWrite` / `dataAddr` / `writeData` alongside dmem, without stalling or altering the CPU.
- Captures every store that falls in a configurable word-address window into a small FIFO, which a host/debug side drains over a valid/ready port.
- Raises a sticky `done` flag when the program writes a configured completion value to a configured completion address.
- Lets program completion be detected in hardware instead of by peeking into RAM.

---
 rtl/dbg_store_sniffer_if.sv | 33 +++
 rtl/dbg_store_sniffer.sv | 104 ++++++++++
 tb/tb_dbg_store_sniffer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_store_sniffer_if.sv
// dbg_store_sniffer_if
// Groups the two buses of the store sniffer:
//   - CPU store tap: memWrite, dataAddr, writeData. These are observed only
//     and never driven back toward the CPU.
//   - Drain port: out_valid, out_ready, out_addr, out_data.
// Drain handshake: the sniffer presents the head entry on out_addr/out_data
// whenever out_valid=1 and holds it stable until a posedge where out_valid
// and out_ready are both 1. That edge pops the entry. out_ready is ignored
// while out_valid=0.
// Modports:
//   master - CPU/host side: drives the store tap and out_ready.
//   slave  - sniffer side: observes the store tap and drives the drain outputs.
interface dbg_store_sniffer_if #(
    parameter int N = 32
);
    logic         memWrite;
    logic [N-1:0] dataAddr;
    logic [N-1:0] writeData;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_addr;
    logic [N-1:0] out_data;

    modport master (
        output memWrite, dataAddr, writeData, out_ready,
        input  out_valid, out_addr, out_data
    );

    modport slave (
        input  memWrite, dataAddr, writeData, out_ready,
        output out_valid, out_addr, out_data
    );
endinterface

// File: rtl/dbg_store_sniffer.sv
// dbg_store_sniffer
// Passive tap on the CPU data-memory store path. Stores to word-aligned
// addresses inside [ADDR_LO, ADDR_HI] are captured into a first-word-fall-
// through FIFO, which is drained over the bus drain port. A sticky done flag
// is raised when DONE_VALUE is stored to DONE_ADDR.
// Ports:
//   clk      - single clock, all state updates on posedge
//   reset    - asynchronous active-low reset
//   clear    - synchronous clear of FIFO, flags and counters
//   bus      - store tap and drain port (slave modport)
//   count    - FIFO occupancy, 0..DEPTH
//   overflow - sticky: a qualifying store was dropped because the FIFO was full
//   dropped  - saturating count of dropped stores
//   done     - sticky completion flag
module dbg_store_sniffer #(
    parameter int           N          = 32,
    parameter logic [N-1:0] ADDR_LO    = 'h0000_0040,
    parameter logic [N-1:0] ADDR_HI    = 'h0000_007C,
    parameter logic [N-1:0] DONE_ADDR  = 'h0000_0054,
    parameter logic [N-1:0] DONE_VALUE = 'h0000_0096,
    parameter int           DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    dbg_store_sniffer_if.slave     bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             dropped,
    output logic                   done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  memAddr [DEPTH];
    logic [N-1:0]  memData [DEPTH];
    logic [AW-1:0] headPtr;
    logic [AW-1:0] tailPtr;

    logic qualify;
    logic full;
    logic doPop;
    logic doPush;
    logic doDrop;
    logic doneHit;

    assign qualify = bus.memWrite
                   && (bus.dataAddr >= ADDR_LO)
                   && (bus.dataAddr <= ADDR_HI)
                   && (bus.dataAddr[1:0] == 2'b00);
    assign full    = (count == CW'(DEPTH));
    assign doPop   = bus.out_valid && bus.out_ready;
    // A pop in the same edge frees a slot, so a full FIFO still accepts.
    assign doPush  = qualify && (!full || doPop);
    assign doDrop  = qualify && full && !doPop;
    assign doneHit = bus.memWrite && (bus.dataAddr == DONE_ADDR)
                   && (bus.writeData == DONE_VALUE);

    // Head outputs are forced to zero when empty so that reset and clear
    // present zeros regardless of the stale storage contents.
    assign bus.out_valid = (count != '0);
    assign bus.out_addr  = bus.out_valid ? memAddr[headPtr] : '0;
    assign bus.out_data  = bus.out_valid ? memData[headPtr] : '0;

    // Storage holds no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (reset && !clear && doPush) begin
            memAddr[tailPtr] <= bus.dataAddr;
            memData[tailPtr] <= bus.writeData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
            done     <= 1'b0;
        end else if (clear) begin
            // Clear beats any same-cycle push, pop, drop or completion match.
            headPtr  <= '0;
            tailPtr  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
            done     <= 1'b0;
        end else begin
            if (doPush) tailPtr <= tailPtr + AW'(1);
            if (doPop)  headPtr <= headPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (doDrop) begin
                overflow <= 1'b1;
                if (dropped != 8'hFF) dropped <= dropped + 8'd1;
            end
            if (doneHit) done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dbg_store_sniffer.sv
module tb_dbg_store_sniffer;
    logic       clk;
    logic       reset;
    logic       clear;
    logic [3:0] count;
    logic       overflow;
    logic [7:0] dropped;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard of expected FIFO contents, {addr, data}.
    logic [63:0] exp_q[$];

    dbg_store_sniffer_if #(.N(32)) bus ();

    dbg_store_sniffer dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus.slave),
        .count    (count),
        .overflow (overflow),
        .dropped  (dropped),
        .done     (done)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        clr;
        logic [3:0]  eCnt;
        logic        eVld;
        logic [31:0] eAddr;
        logic [31:0] eData;
        logic        eOvf;
        logic [7:0]  eDrp;
        logic        eDn;
    } vec_t;

    vec_t vecs [14];

    // Driver tasks
    task automatic drive(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic rdy,
                         input logic clr);
        bus.memWrite  = we;
        bus.dataAddr  = addr;
        bus.writeData = data;
        bus.out_ready = rdy;
        clear         = clr;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checking
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic [3:0] eCnt,
                            input logic eVld, input logic [31:0] eAddr,
                            input logic [31:0] eData, input logic eOvf,
                            input logic [7:0] eDrp, input logic eDn);
        check({name, ".count"},    32'(count),         32'(eCnt));
        check({name, ".valid"},    32'(bus.out_valid), 32'(eVld));
        check({name, ".addr"},     bus.out_addr,       eAddr);
        check({name, ".data"},     bus.out_data,       eData);
        check({name, ".overflow"}, 32'(overflow),      32'(eOvf));
        check({name, ".dropped"},  32'(dropped),       32'(eDrp));
        check({name, ".done"},     32'(done),          32'(eDn));
    endtask

    // Pops every scoreboard entry through the drain port, checking each head.
    task automatic drainAll(input string name);
        logic [63:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, ".valid"}, 32'(bus.out_valid), 32'd1);
            check({name, ".addr"},  bus.out_addr, e[63:32]);
            check({name, ".data"},  bus.out_data, e[31:0]);
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            step();
        end
        idle();
        check({name, ".empty_count"}, 32'(count), 32'd0);
        check({name, ".empty_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic doClear();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        idle();
    endtask

    initial begin
        //         we    addr        data        rdy   clr   cnt vld addr        data        ovf   drp   dn
        vecs[0]  = '{1'b1, 32'h00, 32'h05, 1'b0, 1'b0, 4'd0, 1'b0, 32'h00, 32'h00, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 32'h80, 32'h06, 1'b0, 1'b0, 4'd0, 1'b0, 32'h00, 32'h00, 1'b0, 8'd0, 1'b0};
        vecs[2]  = '{1'b1, 32'h40, 32'h11, 1'b0, 1'b0, 4'd1, 1'b1, 32'h40, 32'h11, 1'b0, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 4'd1, 1'b1, 32'h40, 32'h11, 1'b0, 8'd0, 1'b0};
        vecs[4]  = '{1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 4'd0, 1'b0, 32'h00, 32'h00, 1'b0, 8'd0, 1'b0};
        vecs[5]  = '{1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 4'd0, 1'b0, 32'h00, 32'h00, 1'b0, 8'd0, 1'b0};
        vecs[6]  = '{1'b1, 32'h54, 32'h96, 1'b0, 1'b0, 4'd1, 1'b1, 32'h54, 32'h96, 1'b0, 8'd0, 1'b1};
        vecs[7]  = '{1'b1, 32'h54, 32'h95, 1'b0, 1'b0, 4'd2, 1'b1, 32'h54, 32'h96, 1'b0, 8'd0, 1'b1};
        vecs[8]  = '{1'b1, 32'h55, 32'h96, 1'b0, 1'b0, 4'd2, 1'b1, 32'h54, 32'h96, 1'b0, 8'd0, 1'b1};
        vecs[9]  = '{1'b1, 32'h3C, 32'h01, 1'b0, 1'b0, 4'd2, 1'b1, 32'h54, 32'h96, 1'b0, 8'd0, 1'b1};
        vecs[10] = '{1'b1, 32'h7C, 32'h02, 1'b0, 1'b0, 4'd3, 1'b1, 32'h54, 32'h96, 1'b0, 8'd0, 1'b1};
        vecs[11] = '{1'b0, 32'h00, 32'h00, 1'b0, 1'b1, 4'd0, 1'b0, 32'h00, 32'h00, 1'b0, 8'd0, 1'b0};
        vecs[12] = '{1'b1, 32'h54, 32'h96, 1'b0, 1'b1, 4'd0, 1'b0, 32'h00, 32'h00, 1'b0, 8'd0, 1'b0};
        vecs[13] = '{1'b0, 32'h00, 32'h00, 1'b0, 1'b0, 4'd0, 1'b0, 32'h00, 32'h00, 1'b0, 8'd0, 1'b0};

        reset = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        checkAll("reset", 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 8'd0, 1'b0);
        reset = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].rdy, vecs[i].clr);
            step();
            checkAll($sformatf("vec%0d", i), vecs[i].eCnt, vecs[i].eVld,
                     vecs[i].eAddr, vecs[i].eData, vecs[i].eOvf,
                     vecs[i].eDrp, vecs[i].eDn);
        end

        // Overflow: 10 stores into an 8-entry FIFO, two are dropped
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i), 32'(i + 1), 1'b0, 1'b0);
            if (i < 8) exp_q.push_back({32'h40 + 32'(4 * i), 32'(i + 1)});
            step();
            check($sformatf("fill%0d.count", i), 32'(count), (i < 8) ? 32'(i + 1) : 32'd8);
        end
        idle();
        check("ovf.overflow", 32'(overflow), 32'd1);
        check("ovf.dropped",  32'(dropped),  32'd2);
        drainAll("drain1");
        check("ovf.sticky", 32'(overflow), 32'd1);
        doClear();
        check("clr.overflow", 32'(overflow), 32'd0);
        check("clr.dropped",  32'(dropped),  32'd0);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i), 32'h20 + 32'(i), 1'b0, 1'b0);
            exp_q.push_back({32'h40 + 32'(4 * i), 32'h20 + 32'(i)});
            step();
        end
        check("full.count", 32'(count), 32'd8);
        begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("pp.head_addr", bus.out_addr, e[63:32]);
            check("pp.head_data", bus.out_data, e[31:0]);
        end
        drive(1'b1, 32'h44, 32'hAA, 1'b1, 1'b0);
        exp_q.push_back({32'h44, 32'hAA});
        step();
        idle();
        check("pp.count",    32'(count),    32'd8);
        check("pp.overflow", 32'(overflow), 32'd0);
        check("pp.dropped",  32'(dropped),  32'd0);
        drainAll("drain2");
        doClear();

        // Dropped counter saturates at 255
        for (int i = 0; i < 268; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * (i % 16)), 32'(i), 1'b0, 1'b0);
            step();
        end
        idle();
        check("sat.count",    32'(count),    32'd8);
        check("sat.overflow", 32'(overflow), 32'd1);
        check("sat.dropped",  32'(dropped),  32'd255);
        doClear();

        // Asynchronous reset mid-cycle with five entries and done set
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h44 + 32'(4 * i), (i == 4) ? 32'h96 : 32'(i + 1), 1'b0, 1'b0);
            step();
        end
        idle();
        check("pre_rst.count", 32'(count), 32'd5);
        check("pre_rst.done",  32'(done),  32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkAll("async_rst", 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'h48, 32'h7, 1'b0, 1'b0);
        step();
        idle();
        checkAll("post_rst", 4'd1, 1'b1, 32'h48, 32'h7, 1'b0, 8'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
